// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset control sequencer.
package mc_ctrl_pkg;

  localparam int OPC_W   = 6;
  localparam int ALUOP_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_R       = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_ADDI    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } cls_e;

  localparam logic [OPC_W-1:0] OPC_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 3'b010;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Datapath control bundle between the sequencer (master) and the datapath (slave).
interface mc_ctrl_if #(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 3
);
  logic [OPC_W-1:0]   opcode;
  logic               zf;
  logic               mem_ready;
  logic               ir_write;
  logic               pc_write;
  logic               pc_src;
  logic               reg_dst;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               mem_req;
  logic               mem_write;
  logic               mem_to_reg;
  logic               reg_write;
  logic               instr_done;
  logic               trap;

  modport master (
    input  opcode, zf, mem_ready,
    output ir_write, pc_write, pc_src, reg_dst, alu_src, alu_op,
           mem_req, mem_write, mem_to_reg, reg_write, instr_done, trap
  );

  modport slave (
    output opcode, zf, mem_ready,
    input  ir_write, pc_write, pc_src, reg_dst, alu_src, alu_op,
           mem_req, mem_write, mem_to_reg, reg_write, instr_done, trap
  );
endinterface

// File: rtl/mc_opc_decode.sv
// Combinational opcode-to-instruction-class decoder; unknown opcodes map to ILLEGAL.
module mc_opc_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output cls_e             cls
);

  // Classify the IR opcode field.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_R:    cls = CLS_R;
      OPC_LW:   cls = CLS_LW;
      OPC_SW:   cls = CLS_SW;
      OPC_BEQ:  cls = CLS_BEQ;
      OPC_ADDI: cls = CLS_ADDI;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP) for the MIPS-subset datapath.
// Define MC_CTRL_PERF_EN to add the cyc_cnt / ret_cnt performance counters.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      run,
  mc_ctrl_if.master bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  cls_e   dec_cls_s;

  logic               ir_write_s;
  logic               pc_write_s;
  logic               pc_src_s;
  logic               reg_dst_s;
  logic               alu_src_s;
  logic [ALUOP_W-1:0] alu_op_s;
  logic               mem_req_s;
  logic               mem_write_s;
  logic               mem_to_reg_s;
  logic               reg_write_s;
  logic               instr_done_s;
  logic               trap_s;

  mc_opc_decode #(.OPC_W(OPC_W)) u_dec (
    .opcode (bus.opcode),
    .cls    (dec_cls_s)
  );

  // State and latched instruction class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state logic; the class is captured only in DECODE.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = dec_cls_s;
        if (dec_cls_s == CLS_ILLEGAL) state_d = ST_TRAP;
        else                          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BEQ: begin
            if (run) state_d = ST_FETCH;
            else     state_d = ST_IDLE;
          end
          CLS_R, CLS_ADDI: state_d = ST_WB;
          CLS_LW, CLS_SW:  state_d = ST_MEM;
          default:         state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (!bus.mem_ready) begin
          state_d = ST_MEM;
        end else if (cls_q == CLS_SW) begin
          if (run) state_d = ST_FETCH;
          else     state_d = ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from state and class; zf and mem_ready are the only Mealy inputs.
  always_comb begin
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    reg_dst_s    = 1'b0;
    alu_src_s    = 1'b0;
    alu_op_s     = ALUOP_ADD;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    trap_s       = 1'b0;
    case (state_q)
      ST_FETCH: ir_write_s = 1'b1;
      ST_EXEC: begin
        case (cls_q)
          CLS_R:                   alu_op_s = ALUOP_FUNC;
          CLS_LW, CLS_SW, CLS_ADDI: alu_src_s = 1'b1;
          CLS_BEQ: begin
            alu_op_s     = ALUOP_SUB;
            pc_write_s   = 1'b1;
            pc_src_s     = bus.zf;
            instr_done_s = 1'b1;
          end
          default: alu_op_s = ALUOP_ADD;
        endcase
      end
      ST_MEM: begin
        mem_req_s   = 1'b1;
        mem_write_s = (cls_q == CLS_SW);
        alu_src_s   = 1'b1;
        // A store retires in the very cycle memory accepts it.
        if ((cls_q == CLS_SW) && bus.mem_ready) begin
          pc_write_s   = 1'b1;
          instr_done_s = 1'b1;
        end else begin
          pc_write_s   = 1'b0;
          instr_done_s = 1'b0;
        end
      end
      ST_WB: begin
        reg_write_s  = 1'b1;
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
        reg_dst_s    = (cls_q == CLS_R);
        mem_to_reg_s = (cls_q == CLS_LW);
      end
      ST_TRAP: trap_s = 1'b1;
      default: ir_write_s = 1'b0;
    endcase
  end

  assign bus.ir_write   = ir_write_s;
  assign bus.pc_write   = pc_write_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.alu_src    = alu_src_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.mem_req    = mem_req_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.instr_done = instr_done_s;
  assign bus.trap       = trap_s;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] ret_cnt_q, ret_cnt_d;
  logic        busy_s;

  assign busy_s = (state_q != ST_IDLE) && (state_q != ST_TRAP);

  // Counter updates; both wrap naturally at 2^32.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (busy_s) cyc_cnt_d = cyc_cnt_q + 32'd1;
    else        cyc_cnt_d = cyc_cnt_q;
    if (instr_done_s) ret_cnt_d = ret_cnt_q + 32'd1;
    else              ret_cnt_d = ret_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= 32'd0;
      ret_cnt_q <= 32'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule
